// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-line parser.
// Holds the ASCII byte values the parser recognises, the error codes reported
// on err_code, the parser state encoding and small byte-classification helpers.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UZ    = 8'h5A;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LZ    = 8'h7A;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHAR    = 2'd1;
  localparam logic [1:0] ERR_OVF     = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SEP,
    ARG,
    TAIL,
    DISCARD
  } state_e;

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  function automatic logic is_letter(input logic [7:0] b);
    return ((b >= ASCII_UA) && (b <= ASCII_UZ)) ||
           ((b >= ASCII_LA) && (b <= ASCII_LZ));
  endfunction

endpackage

// File: rtl/uart_cmd_parser_dec_accum.sv
// Registered decimal accumulator: acc <- acc*10 + digit.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the accumulator)
//   clr_i     : clear accumulator to 0
//   load_i    : load accumulator with digit_i (first digit of a number)
//   step_i    : acc <- acc*10 + digit_i (ignored when ovf_o is set)
//   digit_i   : decimal digit value 0..9
//   acc_o     : current accumulator value
//   ovf_o     : combinational; a step with the present digit would exceed 2^ARG_W-1
module dec_accum #(
  parameter int ARG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [3:0]       digit_i,
  output logic [ARG_W-1:0] acc_o,
  output logic             ovf_o
);

  // Four extra bits hold acc*10+9 for any in-range acc.
  localparam int WIDE_W = ARG_W + 4;

  logic [ARG_W-1:0]  acc_q, acc_d;
  logic [WIDE_W-1:0] next_wide;

  assign next_wide = ({4'b0000, acc_q} * WIDE_W'(10)) + WIDE_W'(digit_i);
  assign ovf_o     = |next_wide[WIDE_W-1:ARG_W];
  assign acc_o     = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = ARG_W'(digit_i);
    end else if (step_i && !ovf_o) begin
      acc_d = next_wide[ARG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command-line parser for the UART receive path.
// Parses "<letter>[ <decimal>]<CR|LF>" lines from the byte stream and presents
// each complete line once on a valid/ready port; malformed lines give a
// one-cycle cmd_error pulse with a sticky err_code.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   rx_data, new_rx_data : received byte and its one-cycle strobe
//   cmd_char             : command letter (case preserved)
//   cmd_arg, cmd_has_arg : decoded argument, and whether any digit was present
//   cmd_valid, cmd_ready : command handshake; outputs held while valid & !ready
//   cmd_error, err_code  : error pulse; code 1=bad char, 2=overflow, 3=overrun
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ARG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [7:0]       cmd_char,
  output logic [ARG_W-1:0] cmd_arg,
  output logic             cmd_has_arg,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_error,
  output logic [1:0]       err_code
);

  state_e           state_q, state_d;
  logic [7:0]       wchar_q, wchar_d;
  logic             has_arg_q, has_arg_d;
  logic [1:0]       disc_code_q, disc_code_d;

  logic             cmd_valid_q, cmd_valid_d;
  logic [7:0]       cmd_char_q, cmd_char_d;
  logic [ARG_W-1:0] cmd_arg_q, cmd_arg_d;
  logic             cmd_has_arg_q, cmd_has_arg_d;
  logic             cmd_error_q, cmd_error_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             acc_clr, acc_load, acc_step, acc_ovf;
  logic [ARG_W-1:0] acc_val;
  logic             complete, disc_fire;
  logic             accept, load_cmd, overrun;

  dec_accum #(.ARG_W(ARG_W)) u_accum (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (acc_clr),
    .load_i  (acc_load),
    .step_i  (acc_step),
    .digit_i (rx_data[3:0]),
    .acc_o   (acc_val),
    .ovf_o   (acc_ovf)
  );

  // Line parser: classifies each strobed byte and flags completion / discard.
  always_comb begin
    state_d     = state_q;
    wchar_d     = wchar_q;
    has_arg_d   = has_arg_q;
    disc_code_d = disc_code_q;
    acc_clr     = 1'b0;
    acc_load    = 1'b0;
    acc_step    = 1'b0;
    complete    = 1'b0;
    disc_fire   = 1'b0;
    if (new_rx_data) begin
      unique case (state_q)
        IDLE: begin
          if (is_letter(rx_data)) begin
            wchar_d   = rx_data;
            has_arg_d = 1'b0;
            acc_clr   = 1'b1;
            state_d   = SEP;
          end else if (!is_term(rx_data) && (rx_data != ASCII_SPACE)) begin
            disc_code_d = ERR_CHAR;
            state_d     = DISCARD;
          end
        end
        SEP: begin
          if (rx_data == ASCII_SPACE) begin
            state_d = SEP;
          end else if (is_digit(rx_data)) begin
            acc_load  = 1'b1;
            has_arg_d = 1'b1;
            state_d   = ARG;
          end else if (is_term(rx_data)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            disc_code_d = ERR_CHAR;
            state_d     = DISCARD;
          end
        end
        ARG: begin
          if (is_digit(rx_data)) begin
            if (acc_ovf) begin
              disc_code_d = ERR_OVF;
              state_d     = DISCARD;
            end else begin
              acc_step = 1'b1;
            end
          end else if (rx_data == ASCII_SPACE) begin
            state_d = TAIL;
          end else if (is_term(rx_data)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            disc_code_d = ERR_CHAR;
            state_d     = DISCARD;
          end
        end
        TAIL: begin
          if (is_term(rx_data)) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else if (rx_data != ASCII_SPACE) begin
            disc_code_d = ERR_CHAR;
            state_d     = DISCARD;
          end
        end
        DISCARD: begin
          // The code latched on entry is kept; later faults in the line are ignored.
          if (is_term(rx_data)) begin
            disc_fire = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register: a completed line loads only if the slot is free
  // or being emptied in this same cycle; otherwise it is an overrun.
  always_comb begin
    accept        = cmd_valid_q & cmd_ready;
    load_cmd      = complete & (~cmd_valid_q | accept);
    overrun       = complete & cmd_valid_q & ~cmd_ready;
    cmd_valid_d   = cmd_valid_q & ~accept;
    cmd_char_d    = cmd_char_q;
    cmd_arg_d     = cmd_arg_q;
    cmd_has_arg_d = cmd_has_arg_q;
    cmd_error_d   = 1'b0;
    err_code_d    = err_code_q;
    if (load_cmd) begin
      cmd_valid_d   = 1'b1;
      cmd_char_d    = wchar_q;
      cmd_arg_d     = has_arg_q ? acc_val : '0;
      cmd_has_arg_d = has_arg_q;
    end
    if (overrun) begin
      cmd_error_d = 1'b1;
      err_code_d  = ERR_OVERRUN;
    end
    if (disc_fire) begin
      cmd_error_d = 1'b1;
      err_code_d  = disc_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wchar_q       <= '0;
      has_arg_q     <= 1'b0;
      disc_code_q   <= ERR_NONE;
      cmd_valid_q   <= 1'b0;
      cmd_char_q    <= '0;
      cmd_arg_q     <= '0;
      cmd_has_arg_q <= 1'b0;
      cmd_error_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      wchar_q       <= wchar_d;
      has_arg_q     <= has_arg_d;
      disc_code_q   <= disc_code_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_char_q    <= cmd_char_d;
      cmd_arg_q     <= cmd_arg_d;
      cmd_has_arg_q <= cmd_has_arg_d;
      cmd_error_q   <= cmd_error_d;
      err_code_q    <= err_code_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_char    = cmd_char_q;
  assign cmd_arg     = cmd_arg_q;
  assign cmd_has_arg = cmd_has_arg_q;
  assign cmd_error   = cmd_error_q;
  assign err_code    = err_code_q;

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Receive-side companion to the UART message printer. Consumes the byte stream from the UART receiver (rx_data/new_rx_data) and parses ASCII command lines of the form "<letter>[ <decimal>]<CR|LF>". Each complete line is presented once on a valid/ready command port. Malformed lines produce a one-cycle error pulse.

Parameters:
ARG_W, 16, width of the decoded decimal argument; legal values 0 .. 2^ARG_W-1.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
rx_data  in  8  received byte; valid only when new_rx_data=1
new_rx_data  in  1  one-cycle strobe; byte accepted unconditionally (no backpressure)
cmd_char  out  8  command letter as received (case preserved)
cmd_arg  out  ARG_W  decoded argument; 0 when cmd_has_arg=0
cmd_has_arg  out  1  line contained at least one digit
cmd_valid  out  1  command pending; held until accepted
cmd_ready  in  1  consumer accepts; transfer when cmd_valid & cmd_ready
cmd_error  out  1  one-cycle pulse: line rejected
err_code  out  2  1=bad char, 2=arg overflow, 3=overrun; held from pulse until next pulse

Behaviour:
- Reset: state=IDLE; cmd_valid=0, cmd_error=0, err_code=0, cmd_char=0, cmd_arg=0, cmd_has_arg=0; accumulator cleared. Reset mid-line discards the partial line, and any pending command is dropped.
- Bytes are only examined in cycles with new_rx_data=1. Terminator = 0x0D or 0x0A. Space = 0x20. Letter = A-Z / a-z. Digit = '0'-'9'.
- IDLE: terminator or space -> stay (empty lines and leading blanks ignored). Letter -> latch into working char, clear accumulator -> SEP. Other -> DISCARD with err=1.
- SEP: space -> stay. Digit -> acc=digit, has_arg=1 -> ARG. Terminator -> COMPLETE. Other -> DISCARD err=1.
- ARG: digit -> acc = acc*10 + digit. The computation uses ARG_W+4 bits. If the result exceeds 2^ARG_W-1 -> DISCARD err=2. Space -> TAIL. Terminator -> COMPLETE. Other -> DISCARD err=1.
- TAIL: space -> stay. Terminator -> COMPLETE. Other -> DISCARD err=1.
- DISCARD: ignore all bytes until a terminator. On the terminator, pulse cmd_error with the latched code the following cycle -> IDLE. A later fault in the same line does not overwrite the first code.
- COMPLETE (taken on the terminator byte): if cmd_valid=0, or cmd_valid & cmd_ready in that same cycle:
  - load cmd_char/cmd_arg/cmd_has_arg;
  - cmd_valid=1 the next cycle (latency 1 clk from terminator strobe).
  Otherwise the new line is dropped, cmd_error pulses with err_code=3 next cycle, and the pending command is kept unchanged. State -> IDLE in all cases.
- cmd_valid falls the cycle after cmd_valid & cmd_ready unless a new command loads in the same cycle. Outputs are stable while cmd_valid=1 & cmd_ready=0.
- CR LF pair: the second terminator is seen in IDLE and ignored, so it never creates an empty command.
- Byte parsing continues while a command is pending; only completion can overrun.
- cmd_ready with cmd_valid=0 has no effect.

Decomposition:
- Shared package uart_cmd_pkg:
  - ASCII constants CR, LF, SPACE, '0', '9', 'A', 'Z', 'a', 'z';
  - err_code localparams ERR_NONE/ERR_CHAR/ERR_OVF/ERR_OVERRUN;
  - state encodings IDLE/SEP/ARG/TAIL/DISCARD.
- One sub-module, dec_accum: registered multiply-by-10-plus-digit accumulator with clear, load, step and overflow flag, parameterised by ARG_W.
- The parser FSM plus the output holding register form the top.

Test Plan:
- "h\r" -> one cycle after the CR strobe: cmd_valid=1, cmd_char=0x68, cmd_has_arg=0, cmd_arg=0; cmd_ready=1 -> cmd_valid=0 next cycle.
- "s 1234\r\n" with cmd_ready=1 -> exactly one command: cmd_char=0x73, cmd_arg=1234, cmd_has_arg=1; the LF produces nothing.
- "w 65535\r" then "w 65536\r" (ARG_W=16) -> first gives cmd_arg=65535. Second gives a cmd_error pulse, err_code=2, and no cmd_valid.
- "x 1a2\r" and "7\r" -> each gives one cmd_error pulse with err_code=1 on the cycle after the CR; the state returns to IDLE; a following "h\r" parses correctly.
- cmd_ready held 0, send "a 1\r" then "b 2\r" -> first is held (cmd_char=0x61, cmd_arg=1). Second gives a cmd_error pulse with err_code=3. Raising cmd_ready transfers "a 1" only.
- Assert rst for 1 cycle mid "s 12" with a command pending -> all outputs return to reset values; a subsequent "s 3\r" yields cmd_arg=3.
